// File: rtl/fft_peak_sort.sv
// Scans one frame of FFT magnitudes and finds the DC bin and the AC peak in BIN_LO..BIN_HI.
// It converts the peak bin index to heart rate in BPM and publishes all three results together.
module fft_peak_sort #(
  parameter int N_BINS   = 512,
  parameter int SKIP     = 1,
  parameter int BIN_LO   = 7,
  parameter int BIN_HI   = 34,
  parameter int HR_SCALE = 375,
  parameter int HR_SHIFT = 6,
  parameter int GAP_MAX  = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sqrt_dv,
  input  logic [23:0] data_from_sqrt,
  output logic [23:0] AC_comp,
  output logic [23:0] DC_comp,
  output logic [9:0]  HR,
  output logic        sort_DV,
  output logic        frame_err
);

  localparam int TOTAL = SKIP + N_BINS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int GW    = $clog2(GAP_MAX + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, CALC, EMIT} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [GW-1:0]   gap_reg;
  logic [23:0]     max_reg;
  logic [CW-1:0]   idx_reg;
  logic [23:0]     dc_reg;

  logic [CW-1:0]   k_cur;
  logic [CW-1:0]   bin_cur;
  logic            is_bin;
  logic            is_last;
  logic            in_win;
  logic [23:0]     max_base;
  logic [CW-1:0]   idx_base;
  logic [23:0]     dc_base;
  logic [23:0]     max_next;
  logic [CW-1:0]   idx_next;
  logic [23:0]     dc_next;
  logic [24:0]     hr_prod;
  logic [24:0]     hr_raw;
  logic [9:0]      hr_sat;

  // The strobe that starts a frame arrives in IDLE, so it is processed as strobe 0
  // against freshly cleared trackers rather than the previous frame's leftovers.
  always_comb begin
    k_cur    = (state_reg == IDLE) ? '0 : cnt_reg;
    bin_cur  = k_cur - CW'(SKIP);
    is_bin   = (k_cur >= CW'(SKIP));
    is_last  = (k_cur == CW'(TOTAL - 1));
    in_win   = is_bin && (bin_cur >= CW'(BIN_LO)) && (bin_cur <= CW'(BIN_HI));
    max_base = (state_reg == IDLE) ? '0 : max_reg;
    idx_base = (state_reg == IDLE) ? CW'(BIN_LO) : idx_reg;
    dc_base  = (state_reg == IDLE) ? '0 : dc_reg;
    max_next = max_base;
    idx_next = idx_base;
    dc_next  = dc_base;
    if (is_bin && (bin_cur == '0))
      dc_next = data_from_sqrt;
    // Strictly greater keeps the lowest bin on ties.
    if (in_win && (data_from_sqrt > max_base)) begin
      max_next = data_from_sqrt;
      idx_next = bin_cur;
    end
  end

  always_comb begin
    hr_prod = 25'(idx_reg) * 25'(HR_SCALE);
    hr_raw  = hr_prod >> HR_SHIFT;
    hr_sat  = (|hr_raw[24:10]) ? 10'd1023 : hr_raw[9:0];
  end

  // Results are loaded on the CALC->EMIT edge so they and sort_DV are visible
  // during the EMIT cycle, two cycles after the final-bin strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      gap_reg   <= '0;
      max_reg   <= '0;
      idx_reg   <= CW'(BIN_LO);
      dc_reg    <= '0;
      AC_comp   <= '0;
      DC_comp   <= '0;
      HR        <= '0;
      sort_DV   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sort_DV   <= 1'b0;
      frame_err <= 1'b0;
      case (state_reg)
        IDLE, COLLECT: begin
          if (sqrt_dv) begin
            cnt_reg   <= k_cur + CW'(1);
            gap_reg   <= '0;
            max_reg   <= max_next;
            idx_reg   <= idx_next;
            dc_reg    <= dc_next;
            state_reg <= is_last ? CALC : COLLECT;
          end else if (state_reg == COLLECT) begin
            if (gap_reg >= GW'(GAP_MAX - 1)) begin
              gap_reg   <= GW'(GAP_MAX);
              frame_err <= 1'b1;
              state_reg <= IDLE;
            end else begin
              gap_reg <= gap_reg + GW'(1);
            end
          end
        end
        CALC: begin
          AC_comp   <= max_reg;
          DC_comp   <= dc_reg;
          HR        <= hr_sat;
          sort_DV   <= 1'b1;
          frame_err <= sqrt_dv;
          state_reg <= EMIT;
        end
        EMIT: begin
          frame_err <= sqrt_dv;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fft_peak_sort.md
FFT_PEAK_SORT -- requirements
Module: fft_peak_sort

Interface
REQ-001 Parameter N_BINS, default 512: magnitude bins accepted per frame, indices 0..N_BINS-1.
REQ-002 Parameter SKIP, default 1: leading strobes per frame that are discarded (stale first sqrt result).
REQ-003 Parameter BIN_LO, default 7: lowest bin searched for the AC peak.
REQ-004 Parameter BIN_HI, default 34: highest bin searched for the AC peak, inclusive.
REQ-005 Parameter HR_SCALE, default 375: unsigned 16-bit BPM-per-bin multiplier.
REQ-006 Parameter HR_SHIFT, default 6: right shift applied to the HR product.
REQ-007 Parameter GAP_MAX, default 64: idle cycles allowed inside a frame before it is aborted.
REQ-008 clk  in  1  single clock; all state updates on its rising edge.
REQ-009 reset_n  in  1  reset; asynchronous, active-low.
REQ-010 sqrt_dv  in  1  one-cycle strobe; data_from_sqrt is valid this cycle.
REQ-011 data_from_sqrt  in  24  unsigned FFT bin magnitude.
REQ-012 AC_comp  out  24  peak magnitude within BIN_LO..BIN_HI of the last good frame.
REQ-013 DC_comp  out  24  bin-0 magnitude of the last good frame.
REQ-014 HR  out  10  heart rate in BPM derived from the peak bin index.
REQ-015 sort_DV  out  1  one-cycle pulse when AC_comp, DC_comp and HR update.
REQ-016 frame_err  out  1  one-cycle pulse on frame abort or a dropped strobe.

Function
REQ-017 The FSM SHALL have four states: IDLE, COLLECT, CALC, EMIT.
REQ-018 IDLE: the first sqrt_dv SHALL start a frame (counted as strobe 0) and move the FSM to COLLECT.
REQ-019 Strobe k of a frame maps to bin k-SKIP; strobes with k<SKIP SHALL be discarded.
REQ-020 COLLECT: bin 0 SHALL be latched into an internal DC register.
REQ-021 COLLECT: for bins BIN_LO..BIN_HI, a running max SHALL update only on strictly greater magnitude; ties keep the lowest bin.
REQ-022 The running max SHALL be cleared to 0, with index BIN_LO, at frame start.
REQ-023 Bins outside 0 and BIN_LO..BIN_HI SHALL be counted but SHALL NOT affect any result.
REQ-024 On the strobe of bin N_BINS-1, the FSM SHALL go to CALC; strobe total per frame is SKIP+N_BINS.
REQ-025 CALC (1 cycle): hr_raw = (peak_idx * HR_SCALE) >> HR_SHIFT, computed at 25 bits unsigned; HR = min(hr_raw, 1023).
REQ-026 EMIT (1 cycle): AC_comp, DC_comp and HR SHALL be loaded, sort_DV SHALL pulse, and the FSM SHALL return to IDLE.
REQ-027 Latency: sort_DV SHALL assert exactly 2 cycles after the final-bin strobe cycle.
REQ-028 Outputs SHALL hold their values between sort_DV pulses; an aborted frame SHALL NOT change them.
REQ-029 COLLECT: GAP_MAX consecutive cycles without sqrt_dv SHALL abort the frame, pulse frame_err, and return to IDLE.
REQ-030 A sqrt_dv seen in CALC or EMIT SHALL be dropped and SHALL pulse frame_err; the next frame starts from IDLE.
REQ-031 The gap counter SHALL reset on every strobe and saturate at GAP_MAX.
REQ-032 Data values carry no sign; all compares SHALL be unsigned.

Reset
REQ-033 While reset_n=0: FSM=IDLE; all counters, running max and DC register =0; peak index =BIN_LO.
REQ-034 While reset_n=0: AC_comp=0, DC_comp=0, HR=0, sort_DV=0, frame_err=0.
REQ-035 Reset asserted mid-frame SHALL discard the partial frame with no sort_DV and no frame_err.

Verification
REQ-036 Full frame, 513 strobes: skip=0, bin0=5000, bin16=900, others 10 -> sort_DV 2 cycles after the last strobe; DC=5000, AC=900, HR=(16*375)>>6=93.
REQ-037 Tie: bins 10 and 20 both =700, others 1 -> AC=700, HR=(10*375)>>6=58.
REQ-038 Out-of-window peak: bin 3=9999, bin 40=8888, bin 12=50 -> AC=50, HR=70.
REQ-039 Gap: 65 idle cycles after strobe 200 -> frame_err pulse, no sort_DV, outputs keep previous values; next full frame reports normally.
REQ-040 Saturation: HR_SCALE=65535, peak bin 34 -> HR=1023.
REQ-041 Reset: reset_n low at strobe 300 -> all outputs 0 immediately (async); a following clean frame yields correct results.
